ex_alu_unit: RTL and testbench
==============================

# ex_alu_unit

Execute-stage arithmetic core of the five-stage pipeline: it decodes the ALU operation from `aluop` and the instruction funct field, selects the ALU B operand, and computes the ALU result, zero flag and branch-target sum. All three results are registered once per clock so they present in step with the EX/MEM boundary. The block sits between the ID/EX register outputs and the EX/MEM pipeline register.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `stall`  input  1  high: hold all output registers.
- `aluop`  input  2  ALU operation class from main control.
- `alusrc`  input  1  1 = B operand is `s_extend`; 0 = B operand is `rdata2`.
- `npc`  input  32  next PC (PC+1, word-indexed).
- `rdata1`  input  32  ALU A operand.
- `rdata2`  input  32  register B operand.
- `s_extend`  input  32  sign-extended immediate; bits [5:0] are the funct field.
- `alu_result`  output  32  registered ALU result.
- `zero`  output  1  registered; 1 when the ALU result is 0.
- `add_result`  output  32  registered branch target `npc + s_extend`.
- `alu_sel`  output  3  combinational ALU select, for debug and visibility.

## Operation
ALU control (`alu_sel`), combinational:
- `aluop`=00: 010 (add; used by lw/sw).
- `aluop`=01: 110 (sub; used by beq).
- `aluop`=10: decode funct = `s_extend[5:0]`: 100000→010 add; 100010→110 sub; 100100→000 and; 100101→001 or; 101010→111 slt; any other value→011 (invalid).
- `aluop`=11: 011 (invalid).

Operand B: `alusrc` ? `s_extend` : `rdata2`.

ALU, by `alu_sel`:
- 000: A & B.
- 001: A | B.
- 010: A + B, modulo 2^32, no overflow flag.
- 110: A − B, modulo 2^32.
- 111: 32'd1 if A < B as signed two's-complement, else 0.
- 011 and any other code: result 0.
- Zero flag: 1 when the 32-bit ALU result equals 0. An invalid operation therefore gives zero=1.

Branch adder: `npc + s_extend`, modulo 2^32. There is no shift, because the PC is word-indexed. The adder is independent of `aluop` and `alusrc`.

## Timing
- Latency is 1 cycle. Registered outputs update on the rising `clk` after the inputs are applied.
- `rst_n` low: `alu_result`=0, `zero`=0, and `add_result`=0, immediately and asynchronously. They stay there until the first rising edge after `rst_n` goes high.
- `stall` high at a clock edge: all three registered outputs hold their values. `alu_sel` keeps tracking its inputs.
- `rst_n` low overrides `stall`.
- `alu_sel` is purely combinational with no latency.
- There is no handshake: every non-stalled edge captures the current inputs.

## Configuration
- `ALU_NOR_EN` defined:
  - Funct 100111 with `aluop`=10 decodes to `alu_sel`=100.
  - The ALU computes ~(A | B) for `alu_sel`=100.
- `ALU_NOR_EN` undefined:
  - Funct 100111 decodes to 011 (invalid), giving result 0 and zero=1.
  - `alu_sel`=100 is never produced.

## Test plan
- Reset: hold `rst_n`=0 with arbitrary inputs. Required: outputs read 0/0/0; after release, the first edge loads the current results.
- lw path: `aluop`=00, `alusrc`=1, `rdata1`=100, `s_extend`=8, `npc`=5. Required: after one edge, `alu_result`=108, `zero`=0, `add_result`=13.
- beq path: `aluop`=01, `alusrc`=0, `rdata1`=`rdata2`=0x12345678, `npc`=10, `s_extend`=0xFFFFFFFE. Required: `alu_result`=0, `zero`=1, `add_result`=8 (wrap-around).
- R-type sweep, `aluop`=10, `alusrc`=0, `rdata1`=0xF0F0000F, `rdata2`=0x0000FFFF. Required `alu_result` per funct:
  - and: 0x0000000F.
  - or: 0xF0F0FFFF.
  - add: 0xF0F1000E.
  - sub: 0xF0EF0010.
  - slt: 1 (negative < positive).
  - Then swap the operands: slt gives 0.
- Invalid/stall:
  - Funct 000000 with `aluop`=10 gives `alu_sel`=011, `alu_result`=0, `zero`=1.
  - Raising `stall` and changing the inputs leaves the outputs unchanged for 3 edges.
- `ALU_NOR_EN` build: funct 100111, `rdata1`=0x0F, `rdata2`=0xF0. Required: `alu_result`=0xFFFFFF00. In a build without the macro, the same stimulus gives 0.

Source files
------------

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU core: ALU control decode, B-operand mux, ALU, zero flag, branch-target adder.
// Latency: 1 cycle for alu_result/zero/add_result; alu_sel is combinational (0 cycles).
// Backpressure: no handshake; stall high freezes all registered outputs, alu_sel keeps tracking.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   stall               hold registered outputs
//   aluop[1:0]          operation class from main control
//   alusrc              1: B = s_extend, 0: B = rdata2
//   npc[31:0]           next PC (word-indexed)
//   rdata1/rdata2[31:0] register operands A and B
//   s_extend[31:0]      sign-extended immediate, [5:0] doubles as funct
//   alu_result[31:0]    registered ALU result
//   zero                registered, 1 when ALU result is 0
//   add_result[31:0]    registered branch target npc + s_extend
//   alu_sel[2:0]        combinational ALU select (debug visibility)
//
// Build option: define ALU_NOR_EN to add NOR (funct 100111 -> alu_sel 100).
module ex_alu_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  aluop,
  input  logic        alusrc,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extend,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] add_result,
  output logic [2:0]  alu_sel
);

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_INV = 3'b011;
  localparam logic [2:0] SEL_NOR = 3'b100;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

  logic [2:0]  w_alu_sel;
  logic [31:0] w_b;
  logic [31:0] w_alu;
  logic [31:0] w_add;
  logic [31:0] r_alu_result;
  logic        r_zero;
  logic [31:0] r_add_result;

  // ALU control decode
  always_comb begin
    w_alu_sel = SEL_INV;
    case (aluop)
      2'b00: w_alu_sel = SEL_ADD;
      2'b01: w_alu_sel = SEL_SUB;
      2'b10: begin
        case (s_extend[5:0])
          6'b100000: w_alu_sel = SEL_ADD;
          6'b100010: w_alu_sel = SEL_SUB;
          6'b100100: w_alu_sel = SEL_AND;
          6'b100101: w_alu_sel = SEL_OR;
          6'b101010: w_alu_sel = SEL_SLT;
`ifdef ALU_NOR_EN
          6'b100111: w_alu_sel = SEL_NOR;
`endif
          default:   w_alu_sel = SEL_INV;
        endcase
      end
      default: w_alu_sel = SEL_INV;
    endcase
  end

  assign w_b = alusrc ? s_extend : rdata2;

  always_comb begin
    w_alu = 32'd0;
    case (w_alu_sel)
      SEL_AND: w_alu = rdata1 & w_b;
      SEL_OR:  w_alu = rdata1 | w_b;
      SEL_ADD: w_alu = rdata1 + w_b;
      SEL_SUB: w_alu = rdata1 - w_b;
      SEL_SLT: w_alu = ($signed(rdata1) < $signed(w_b)) ? 32'd1 : 32'd0;
`ifdef ALU_NOR_EN
      SEL_NOR: w_alu = ~(rdata1 | w_b);
`endif
      // Invalid selects produce 0, which deliberately reports zero=1.
      default: w_alu = 32'd0;
    endcase
  end

  // PC is word-indexed, so the branch offset is added without a shift.
  assign w_add = npc + s_extend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_result <= 32'd0;
      r_zero       <= 1'b0;
      r_add_result <= 32'd0;
    end else if (!stall) begin
      r_alu_result <= w_alu;
      r_zero       <= (w_alu == 32'd0);
      r_add_result <= w_add;
    end
  end

  assign alu_result = r_alu_result;
  assign zero       = r_zero;
  assign add_result = r_add_result;
  assign alu_sel    = w_alu_sel;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Bench for ex_alu_unit: directed cases from the block's usage scenarios plus randomized traffic
// against a behavioural reference model.
module tb_ex_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  aluop;
  logic        alusrc;
  logic [31:0] npc, rdata1, rdata2, s_extend;
  logic [31:0] alu_result, add_result;
  logic        zero;
  logic [2:0]  alu_sel;

  int n_checks = 0;
  int n_errors = 0;

  // Expected state of the registered outputs.
  logic [31:0] m_res;
  logic        m_zero;
  logic [31:0] m_add;

  always #5 clk = ~clk;

  ex_alu_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .aluop(aluop), .alusrc(alusrc),
    .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
    .alu_result(alu_result), .zero(zero), .add_result(add_result), .alu_sel(alu_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_sel(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return 3'd2;
    if (op == 2'd1) return 3'd6;
    if (op == 2'd3) return 3'd3;
    if (f == 6'h20) return 3'd2;
    if (f == 6'h22) return 3'd6;
    if (f == 6'h24) return 3'd0;
    if (f == 6'h25) return 3'd1;
    if (f == 6'h2A) return 3'd7;
`ifdef ALU_NOR_EN
    if (f == 6'h27) return 3'd4;
`endif
    return 3'd3;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sel == 3'd0) return a & b;
    if (sel == 3'd1) return a | b;
    if (sel == 3'd2) return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
    if (sel == 3'd6) return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
    if (sel == 3'd7) return (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_NOR_EN
    if (sel == 3'd4) return ~(a | b);
`endif
    return 32'd0;
  endfunction

  // Apply one cycle of inputs, check alu_sel combinationally, then the registered outputs.
  task automatic drive(input logic [1:0] op, input logic src, input logic [31:0] np,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                       input logic st);
    logic [2:0]  s;
    logic [31:0] r;
    @(negedge clk);
    aluop = op; alusrc = src; npc = np; rdata1 = a; rdata2 = b; s_extend = se; stall = st;
    #1;
    s = ref_sel(op, se[5:0]);
    check("alu_sel", {29'd0, alu_sel}, {29'd0, s});
    r = ref_alu(s, a, src ? se : b);
    if (!st) begin
      m_res  = r;
      m_zero = (r == 32'd0);
      m_add  = 32'((longint'(np) + longint'(se)) % 64'h1_0000_0000);
    end
    @(posedge clk);
    #1;
    check("alu_result", alu_result, m_res);
    check("zero", {31'd0, zero}, {31'd0, m_zero});
    check("add_result", add_result, m_add);
  endtask

  initial begin
    logic [5:0]  fl [8];
    logic [31:0] se;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h3F};
    m_res = 0; m_zero = 0; m_add = 0;

    // Reset with arbitrary inputs
    rst_n = 1'b0; stall = 1'b0; aluop = 2'd0; alusrc = 1'b1;
    npc = $urandom; rdata1 = $urandom; rdata2 = $urandom; s_extend = $urandom;
    #23;
    check("rst_alu_result", alu_result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_add_result", add_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw path
    drive(2'b00, 1'b1, 32'd5, 32'd100, $urandom, 32'd8, 1'b0);
    check("lw_result", alu_result, 32'd108);
    check("lw_zero", {31'd0, zero}, 32'd0);
    check("lw_target", add_result, 32'd13);

    // beq path with wrapping branch target
    drive(2'b01, 1'b0, 32'd10, 32'h12345678, 32'h12345678, 32'hFFFFFFFE, 1'b0);
    check("beq_result", alu_result, 32'd0);
    check("beq_zero", {31'd0, zero}, 32'd1);
    check("beq_target", add_result, 32'd8);

    // R-type sweep
    drive(2'b10, 1'b0, 32'd0, 32'hF0F0000F, 32'h0000FFFF, 32'h24, 1'b0);
    check("r_and", alu_result, 32'h0000000F);
    drive(2'b10, 1'b0, 32'd0, 32'hF0F0000F, 32'h0000FFFF, 32'h25, 1'b0);
    check("r_or", alu_result, 32'hF0F0FFFF);
    drive(2'b10, 1'b0, 32'd0, 32'hF0F0000F, 32'h0000FFFF, 32'h20, 1'b0);
    check("r_add", alu_result, 32'hF0F1000E);
    drive(2'b10, 1'b0, 32'd0, 32'hF0F0000F, 32'h0000FFFF, 32'h22, 1'b0);
    check("r_sub", alu_result, 32'hF0EF0010);
    drive(2'b10, 1'b0, 32'd0, 32'hF0F0000F, 32'h0000FFFF, 32'h2A, 1'b0);
    check("r_slt", alu_result, 32'd1);
    drive(2'b10, 1'b0, 32'd0, 32'h0000FFFF, 32'hF0F0000F, 32'h2A, 1'b0);
    check("r_slt_swap", alu_result, 32'd0);

    // Invalid funct
    drive(2'b10, 1'b0, 32'd0, 32'h55, 32'h66, 32'h00, 1'b0);
    check("inv_sel", {29'd0, alu_sel}, 32'd3);
    check("inv_result", alu_result, 32'd0);
    check("inv_zero", {31'd0, zero}, 32'd1);
    // aluop=11 is invalid too
    drive(2'b11, 1'b1, 32'd7, 32'h9, 32'h9, 32'h20, 1'b0);

    // Load a known value, then stall for 3 edges with changing inputs
    drive(2'b00, 1'b1, 32'd1, 32'd40, 32'd0, 32'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(2'(i), 1'b0, $urandom, $urandom, $urandom, $urandom, 1'b1);
      check("stall_hold", alu_result, 32'd42);
      check("stall_hold_add", add_result, 32'd3);
    end

    // NOR funct
    drive(2'b10, 1'b0, 32'd0, 32'h0F, 32'hF0, 32'h27, 1'b0);
`ifdef ALU_NOR_EN
    check("nor_result", alu_result, 32'hFFFFFF00);
`else
    check("nor_result", alu_result, 32'd0);
    check("nor_zero", {31'd0, zero}, 32'd1);
`endif

    // Asynchronous reset mid-run, asserted together with stall
    drive(2'b00, 1'b1, 32'd3, 32'd1, 32'd0, 32'd1, 1'b0);
    @(negedge clk);
    #2;
    stall = 1'b1;
    rst_n = 1'b0;
    #1;
    check("arst_alu_result", alu_result, 32'd0);
    check("arst_add_result", add_result, 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold", add_result, 32'd0);
    m_res = 0; m_zero = 0; m_add = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      se = $urandom;
      if ($urandom_range(0, 3) != 0) se[5:0] = fl[$urandom_range(0, 7)];
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 7) == 0) ? se : $urandom, $urandom, se,
            ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
